// File: rtl/cl_stat_resp_bank.sv
// cl_stat_resp_bank
// Bank of independent stat-bus slave responders. Every channel acknowledges each
// accepted request after a fixed latency, serves a small register file and drives
// a registered 8-bit interrupt vector, so the shell never waits on an absent
// subsystem.
//
// Per-channel FSM states:
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | ready; a wr/rd strobe is captured and the latency timer loaded
//   ST_WAIT | latency timer counting down; new strobes are dropped
//   ST_ACK  | stat_ack high for one cycle, rdata driven, write committed
module cl_stat_resp_bank #(
    parameter int          NUM_CH     = 3,
    parameter int          ADDR_W     = 8,
    parameter int          ACK_LAT    = 1,
    parameter logic [31:0] ID_BASE    = 32'h0000_0000,
    parameter logic [31:0] CL_VERSION = 32'hee_ee_ee_00
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*ADDR_W-1:0] stat_addr,
    input  logic [NUM_CH-1:0]        stat_wr,
    input  logic [NUM_CH-1:0]        stat_rd,
    input  logic [NUM_CH*32-1:0]     stat_wdata,
    output logic [NUM_CH-1:0]        stat_ack,
    output logic [NUM_CH*32-1:0]     stat_rdata,
    output logic [NUM_CH*8-1:0]      stat_int
);

    localparam logic [3:0]  LAT_M1    = 4'(ACK_LAT - 1);
    localparam logic [7:0]  ADDR_ID   = 8'h00;
    localparam logic [7:0]  ADDR_VER  = 8'h04;
    localparam logic [7:0]  ADDR_SCR  = 8'h08;
    localparam logic [7:0]  ADDR_CNT  = 8'h0C;
    localparam logic [7:0]  ADDR_PEND = 8'h10;
    localparam logic [7:0]  ADDR_MASK = 8'h14;
    localparam logic [31:0] BAD_DATA  = 32'hBAAD_ADD0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t state     [NUM_CH];
    state_t state_nxt [NUM_CH];

    logic [NUM_CH-1:0]             req;
    logic [NUM_CH-1:0]             capture;
    logic [NUM_CH-1:0]             drop;
    logic [NUM_CH-1:0]             in_ack;
    logic [NUM_CH-1:0]             commit;

    logic [NUM_CH-1:0][3:0]        cnt;
    logic [NUM_CH-1:0][ADDR_W-1:0] cap_addr;
    logic [NUM_CH-1:0][31:0]       cap_wdata;
    logic [NUM_CH-1:0]             cap_wr;
    logic [NUM_CH-1:0]             cap_rd;

    logic [NUM_CH-1:0]             hi_ok;
    logic [NUM_CH-1:0]             sel_id;
    logic [NUM_CH-1:0]             sel_ver;
    logic [NUM_CH-1:0]             sel_scr;
    logic [NUM_CH-1:0]             sel_cnt;
    logic [NUM_CH-1:0]             sel_pend;
    logic [NUM_CH-1:0]             sel_mask;
    logic [NUM_CH-1:0]             bad_addr;

    logic [NUM_CH-1:0][31:0]       scratch;
    logic [NUM_CH-1:0][31:0]       access_cnt;
    logic [NUM_CH-1:0][7:0]        int_pend;
    logic [NUM_CH-1:0][7:0]        int_mask;
    logic [NUM_CH-1:0][7:0]        int_out;
    logic [NUM_CH-1:0][7:0]        pend_set;
    logic [NUM_CH-1:0][7:0]        pend_clr;
    logic [NUM_CH-1:0][31:0]       rdata;

    assign req        = stat_wr | stat_rd;
    assign stat_ack   = in_ack;
    assign stat_rdata = rdata;
    assign stat_int   = int_out;

    // State register for every channel FSM.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst) begin
                state[c] <= ST_IDLE;
            end else begin
                state[c] <= state_nxt[c];
            end
        end
    end

    // Next-state logic: accept in IDLE, count in WAIT, single-cycle ACK; strobes outside IDLE are dropped.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            state_nxt[c] = state[c];
            capture[c]   = 1'b0;
            drop[c]      = 1'b0;
            in_ack[c]    = 1'b0;
            case (state[c])
                ST_IDLE: begin
                    if (req[c]) begin
                        capture[c]   = 1'b1;
                        state_nxt[c] = (ACK_LAT == 1) ? ST_ACK : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    drop[c] = req[c];
                    // Terminal count: this decrement takes the timer to zero.
                    if (cnt[c] == 4'd1) begin
                        state_nxt[c] = ST_ACK;
                    end
                end
                ST_ACK: begin
                    in_ack[c]    = 1'b1;
                    drop[c]      = req[c];
                    state_nxt[c] = ST_IDLE;
                end
                default: begin
                    state_nxt[c] = ST_IDLE;
                end
            endcase
        end
    end

    // Request capture and latency down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_wr    <= '0;
            cap_rd    <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (capture[c]) begin
                    cnt[c]       <= LAT_M1;
                    cap_addr[c]  <= stat_addr[c*ADDR_W +: ADDR_W];
                    cap_wdata[c] <= stat_wdata[c*32 +: 32];
                    cap_wr[c]    <= stat_wr[c];
                    // A combined wr+rd is handled as a write and returns zero data.
                    cap_rd[c]    <= stat_rd[c] & ~stat_wr[c];
                end else if (state[c] == ST_WAIT) begin
                    cnt[c] <= cnt[c] - 4'd1;
                end
            end
        end
    end

    // Address decode of the captured request, read mux and interrupt set/clear terms.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            hi_ok[c]    = ((cap_addr[c] >> 8) == '0);
            sel_id[c]   = hi_ok[c] && (cap_addr[c][7:0] == ADDR_ID);
            sel_ver[c]  = hi_ok[c] && (cap_addr[c][7:0] == ADDR_VER);
            sel_scr[c]  = hi_ok[c] && (cap_addr[c][7:0] == ADDR_SCR);
            sel_cnt[c]  = hi_ok[c] && (cap_addr[c][7:0] == ADDR_CNT);
            sel_pend[c] = hi_ok[c] && (cap_addr[c][7:0] == ADDR_PEND);
            sel_mask[c] = hi_ok[c] && (cap_addr[c][7:0] == ADDR_MASK);
            bad_addr[c] = !(sel_id[c] || sel_ver[c] || sel_scr[c] ||
                            sel_cnt[c] || sel_pend[c] || sel_mask[c]);
            commit[c]   = in_ack[c] & cap_wr[c];

            rdata[c] = 32'h0;
            if (in_ack[c] && cap_rd[c]) begin
                if (sel_id[c]) begin
                    rdata[c] = ID_BASE | {28'h0, 4'(c)};
                end else if (sel_ver[c]) begin
                    rdata[c] = CL_VERSION;
                end else if (sel_scr[c]) begin
                    rdata[c] = scratch[c];
                end else if (sel_cnt[c]) begin
                    rdata[c] = access_cnt[c];
                end else if (sel_pend[c]) begin
                    rdata[c] = {24'h0, int_pend[c]};
                end else if (sel_mask[c]) begin
                    rdata[c] = {24'h0, int_mask[c]};
                end else begin
                    rdata[c] = BAD_DATA;
                end
            end

            // bit0: dropped strobe, bit1: unmapped address acked, bit2: wr+rd collision
            pend_set[c] = {5'b0,
                           capture[c] & stat_wr[c] & stat_rd[c],
                           in_ack[c] & bad_addr[c],
                           drop[c]};
            pend_clr[c] = (commit[c] && sel_pend[c]) ? cap_wdata[c][7:0] : 8'h00;
        end
    end

    // Register file: scratch, mask and the saturating access counter (write-clear wins).
    always_ff @(posedge clk) begin
        if (rst) begin
            scratch    <= '0;
            access_cnt <= '0;
            int_mask   <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (commit[c] && sel_scr[c]) begin
                    scratch[c] <= cap_wdata[c];
                end
                if (commit[c] && sel_mask[c]) begin
                    int_mask[c] <= cap_wdata[c][7:0];
                end
                if (commit[c] && sel_cnt[c]) begin
                    access_cnt[c] <= 32'h0;
                end else if (capture[c] && (access_cnt[c] != 32'hFFFF_FFFF)) begin
                    access_cnt[c] <= access_cnt[c] + 32'd1;
                end
            end
        end
    end

    // Interrupt pending (W1C, set beats clear) and the registered masked interrupt output.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_pend <= '0;
            int_out  <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                int_pend[c] <= (int_pend[c] & ~pend_clr[c]) | pend_set[c];
                int_out[c]  <= int_pend[c] & int_mask[c];
            end
        end
    end

endmodule

// File: tb/tb_cl_stat_resp_bank.sv
// Directed bench for cl_stat_resp_bank: three instances share stimulus and differ in
// ack latency (1, 4 and 8 cycles); each step checks only the instance it targets.
module tb_cl_stat_resp_bank;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N*8-1:0] stat_addr  = '0;
    logic [N-1:0]   stat_wr    = '0;
    logic [N-1:0]   stat_rd    = '0;
    logic [N*32-1:0] stat_wdata = '0;

    logic [N-1:0]    ack_a, ack_b, ack_c;
    logic [N*32-1:0] rdata_a, rdata_b, rdata_c;
    logic [N*8-1:0]  int_a, int_b, int_c;

    int   errors = 0;
    int   checks = 0;
    logic other_seen;

    always #5 clk = ~clk;

    cl_stat_resp_bank #(.NUM_CH(N), .ADDR_W(8), .ACK_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .stat_addr(stat_addr), .stat_wr(stat_wr), .stat_rd(stat_rd),
        .stat_wdata(stat_wdata), .stat_ack(ack_a), .stat_rdata(rdata_a), .stat_int(int_a));

    cl_stat_resp_bank #(.NUM_CH(N), .ADDR_W(8), .ACK_LAT(4), .ID_BASE(32'hA5A5_0000)) dut_b (
        .clk(clk), .rst(rst), .stat_addr(stat_addr), .stat_wr(stat_wr), .stat_rd(stat_rd),
        .stat_wdata(stat_wdata), .stat_ack(ack_b), .stat_rdata(rdata_b), .stat_int(int_b));

    cl_stat_resp_bank #(.NUM_CH(N), .ADDR_W(8), .ACK_LAT(8)) dut_c (
        .clk(clk), .rst(rst), .stat_addr(stat_addr), .stat_wr(stat_wr), .stat_rd(stat_rd),
        .stat_wdata(stat_wdata), .stat_ack(ack_c), .stat_rdata(rdata_c), .stat_int(int_c));

    function automatic logic get_ack(input int inst, input int ch);
        case (inst)
            0:       return ack_a[ch];
            1:       return ack_b[ch];
            default: return ack_c[ch];
        endcase
    endfunction

    function automatic logic [31:0] get_rdata(input int inst, input int ch);
        case (inst)
            0:       return rdata_a[ch*32 +: 32];
            1:       return rdata_b[ch*32 +: 32];
            default: return rdata_c[ch*32 +: 32];
        endcase
    endfunction

    function automatic logic get_others(input int inst, input int ch);
        logic [N-1:0] m;
        m = ~(N'(1) << ch);
        case (inst)
            0:       return |(ack_a & m);
            1:       return |(ack_b & m);
            default: return |(ack_c & m);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input int ch, input logic w, input logic r,
                        input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        stat_wr[ch]             = w;
        stat_rd[ch]             = r;
        stat_addr[ch*8 +: 8]    = a;
        stat_wdata[ch*32 +: 32] = d;
        @(negedge clk);
        stat_wr[ch] = 1'b0;
        stat_rd[ch] = 1'b0;
    endtask

    // Latency counts negedges after the capturing posedge; 0 means no ack within budget.
    task automatic wait_ack(input int inst, input int ch, output int lat, output logic [31:0] rd);
        lat        = 0;
        rd         = '0;
        other_seen = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            other_seen = other_seen | get_others(inst, ch);
            if (get_ack(inst, ch)) begin
                lat = k;
                rd  = get_rdata(inst, ch);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic xact(input int inst, input int ch, input logic w, input logic r,
                        input logic [7:0] a, input logic [31:0] d,
                        input int exp_lat, input logic [31:0] exp_rd, input string tag);
        int          lat;
        logic [31:0] rd;
        send(ch, w, r, a, d);
        wait_ack(inst, ch, lat, rd);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (r) check({tag, "_rdata"}, rd, exp_rd);
        @(negedge clk);
        check({tag, "_ack_len"}, {31'b0, get_ack(inst, ch)}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] rd_seen;

        // Reset state
        do_reset();
        check("rst_ack_a",   {29'b0, ack_a}, 32'h0);
        check("rst_rdata_b", rdata_b[31:0], 32'h0);
        check("rst_int_b",   int_b[23:0], 32'h0);

        // 1: ACK_LAT=1 reads of VERSION and ID
        xact(0, 0, 1'b0, 1'b1, 8'h04, 32'h0, 1, 32'hee_ee_ee_00, "t1_ver");
        xact(0, 2, 1'b0, 1'b1, 8'h00, 32'h0, 1, 32'h0000_0002,   "t1_id2");

        // 2: ACK_LAT=4 scratch write/read on ch1, no acks on other channels
        do_reset();
        xact(1, 1, 1'b1, 1'b0, 8'h08, 32'h1234_5678, 4, 32'h0, "t2_wr");
        check("t2_wr_others", {31'b0, other_seen}, 32'h0);
        xact(1, 1, 1'b0, 1'b1, 8'h08, 32'h0, 4, 32'h1234_5678, "t2_rd");
        check("t2_rd_others", {31'b0, other_seen}, 32'h0);

        // 3: second read during WAIT is dropped and flags INT_PEND[0]
        send(2, 1'b0, 1'b1, 8'h00, 32'h0);
        @(negedge clk);
        stat_rd[2]       = 1'b1;
        stat_addr[23:16] = 8'h00;
        @(negedge clk);
        stat_rd[2] = 1'b0;
        n       = 0;
        rd_seen = '0;
        for (int k = 0; k < 10; k++) begin
            if (ack_b[2]) begin
                n++;
                rd_seen = rdata_b[95:64];
            end
            @(negedge clk);
        end
        check("t3_ack_count", 32'(n), 32'd1);
        check("t3_ack_rdata", rd_seen, 32'hA5A5_0002);
        xact(1, 2, 1'b0, 1'b1, 8'h10, 32'h0, 4, 32'h0000_0001, "t3_pend");
        xact(1, 2, 1'b1, 1'b0, 8'h14, 32'h0000_0001, 4, 32'h0, "t3_mask");
        check("t3_int_lag", {24'h0, int_b[23:16]}, 32'h00);
        @(negedge clk);
        check("t3_int_on", {24'h0, int_b[23:16]}, 32'h01);
        xact(1, 2, 1'b1, 1'b0, 8'h10, 32'h0000_0001, 4, 32'h0, "t3_w1c");
        @(negedge clk);
        check("t3_int_off", {24'h0, int_b[23:16]}, 32'h00);
        xact(1, 2, 1'b0, 1'b1, 8'h10, 32'h0, 4, 32'h0000_0000, "t3_pend_clr");

        // 4: unmapped address and wr+rd collision on ch1
        xact(1, 1, 1'b0, 1'b1, 8'h3C, 32'h0, 4, 32'hBAAD_ADD0, "t4_bad");
        xact(1, 1, 1'b0, 1'b1, 8'h10, 32'h0, 4, 32'h0000_0002, "t4_pend1");
        xact(1, 1, 1'b1, 1'b1, 8'h08, 32'hCAFE_0000, 4, 32'h0, "t4_wrrd");
        xact(1, 1, 1'b0, 1'b1, 8'h10, 32'h0, 4, 32'h0000_0006, "t4_pend2");
        xact(1, 1, 1'b0, 1'b1, 8'h08, 32'h0, 4, 32'hCAFE_0000, "t4_scr");

        // 5: access counter counting, clearing and saturation on ch0
        do_reset();
        for (int i = 0; i < 5; i++) begin
            xact(1, 0, 1'b0, 1'b1, 8'h00, 32'h0, 4, 32'hA5A5_0000, "t5_id");
        end
        xact(1, 0, 1'b0, 1'b1, 8'h0C, 32'h0, 4, 32'd6, "t5_cnt6");
        xact(1, 0, 1'b1, 1'b0, 8'h0C, 32'h55, 4, 32'h0, "t5_clr");
        xact(1, 0, 1'b0, 1'b1, 8'h0C, 32'h0, 4, 32'd1, "t5_cnt1");
        @(negedge clk);
        force dut_b.access_cnt = '1;
        @(negedge clk);
        release dut_b.access_cnt;
        xact(1, 0, 1'b0, 1'b1, 8'h0C, 32'h0, 4, 32'hFFFF_FFFF, "t5_sat");
        xact(1, 0, 1'b1, 1'b0, 8'h00, 32'h0, 4, 32'h0, "t5_ro_wr");
        xact(1, 0, 1'b0, 1'b1, 8'h00, 32'h0, 4, 32'hA5A5_0000, "t5_ro_rd");

        // 6: reset during WAIT with ACK_LAT=8
        do_reset();
        xact(2, 0, 1'b1, 1'b0, 8'h08, 32'hDEAD_BEEF, 8, 32'h0, "t6_scr_wr");
        xact(2, 0, 1'b1, 1'b0, 8'h14, 32'h0000_00FF, 8, 32'h0, "t6_mask_wr");
        xact(2, 0, 1'b0, 1'b1, 8'hF0, 32'h0, 8, 32'hBAAD_ADD0, "t6_bad");
        @(negedge clk);
        check("t6_int_pre", {24'h0, int_c[7:0]}, 32'h02);
        send(0, 1'b0, 1'b1, 8'h08, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            if (ack_c[0]) n++;
            @(negedge clk);
        end
        check("t6_no_ack", 32'(n), 32'd0);
        check("t6_int_rst", {24'h0, int_c[7:0]}, 32'h00);
        xact(2, 0, 1'b0, 1'b1, 8'h08, 32'h0, 8, 32'h0, "t6_scr_rd");
        xact(2, 0, 1'b0, 1'b1, 8'h14, 32'h0, 8, 32'h0, "t6_mask_rd");
        xact(2, 0, 1'b0, 1'b1, 8'h0C, 32'h0, 8, 32'd3, "t6_cnt_rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
